// File: rtl/gf_seq_mult.sv
// rtl/gf_seq_mult.sv - sequential GF(2^W) multiplier, K Horner steps per cycle
module gf_seq_mult #(
  parameter int unsigned    W    = 8,
  parameter logic [W-1:0]   POLY = 'h1B,
  parameter int unsigned    K    = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y
);

  localparam int unsigned N  = W / K;
  localparam int unsigned CW = $clog2(N + 1);

  generate
    if (W < 2 || K < 1 || K > W || (W % K) != 0) begin : g_param_check
      $error("gf_seq_mult: W must be >= 2 and K must divide W");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_nxt;
  logic [W-1:0]   b_nxt;

  function automatic logic [W-1:0] xt(input logic [W-1:0] v);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
  endfunction

  // K chained Horner steps, MSB of the multiplier first
  always_comb begin
    acc_nxt = acc;
    b_nxt   = b_r;
    for (int i = 0; i < int'(K); i++) begin
      acc_nxt = xt(acc_nxt) ^ (b_nxt[W-1] ? a_r : '0);
      b_nxt   = b_nxt << 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            cnt   <= CW'(N);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          b_r <= b_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            y     <= acc_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_seq_mult.sv
// tb/tb_gf_seq_mult.sv - randomized and directed checks of gf_seq_mult in four configurations
module tb_gf_seq_mult;

  localparam int NOPS = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st  [4];
  logic [7:0] av  [4];
  logic [7:0] bv  [4];
  logic       bsy [4];
  logic       dn  [4];
  logic [7:0] y0, y1, y2;
  logic [3:0] y3;

  int checks = 0;
  int failures = 0;
  int dcount [4] = '{default: 0};

  gf_seq_mult #(.W(8), .POLY(8'h1B), .K(1)) u_k1 (
    .clk(clk), .reset_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]),
    .busy(bsy[0]), .done(dn[0]), .y(y0));
  gf_seq_mult #(.W(8), .POLY(8'h1B), .K(2)) u_k2 (
    .clk(clk), .reset_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]),
    .busy(bsy[1]), .done(dn[1]), .y(y1));
  gf_seq_mult #(.W(8), .POLY(8'h1B), .K(8)) u_k8 (
    .clk(clk), .reset_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
    .busy(bsy[2]), .done(dn[2]), .y(y2));
  gf_seq_mult #(.W(4), .POLY(4'h3), .K(1)) u_w4 (
    .clk(clk), .reset_n(rst_n), .start(st[3]), .a(av[3][3:0]), .b(bv[3][3:0]),
    .busy(bsy[3]), .done(dn[3]), .y(y3));

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (dn[i]) dcount[i]++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] yget(input int d);
    case (d)
      0: return y0;
      1: return y1;
      2: return y2;
      default: return {4'h0, y3};
    endcase
  endfunction

  function automatic int wd(input int d);
    return (d == 3) ? 4 : 8;
  endfunction

  function automatic int lat_of(input int d);
    case (d)
      0: return 8;
      1: return 4;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  // shift-and-add product, LSB first, reducing after every doubling
  function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] z, input int d);
    int w = wd(d);
    int p = ((d == 3) ? 'h3 : 'h1B) | (1 << w);
    int aa = x;
    int r = 0;
    for (int i = 0; i < w; i++) begin
      if (z[i]) r = r ^ aa;
      aa = aa << 1;
      if ((aa >> w) & 1) aa = aa ^ p;
    end
    return r[7:0];
  endfunction

  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] z,
                        output int lat, output logic [7:0] yy);
    av[d] = x;
    bv[d] = z;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    check("accept_busy", 32'(bsy[d]), 1);
    lat = 0;
    while (!dn[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    yy = yget(d);
    check("done_busy_low", 32'(bsy[d]), 0);
  endtask

  task automatic rand_proc(input int d);
    int lat;
    logic [7:0] yy, x, z, m;
    m = (wd(d) == 4) ? 8'h0F : 8'hFF;
    repeat (NOPS) begin
      x = 8'($urandom);
      z = 8'($urandom);
      case ($urandom_range(0, 7))
        0: x = 8'h00;
        1: z = 8'h00;
        2: z = 8'h01;
        default: ;
      endcase
      x = x & m;
      z = z & m;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(d, x, z, lat, yy);
      check($sformatf("rand%0d_y", d), yy, gf_ref(x, z, d));
      check($sformatf("rand%0d_lat", d), lat, lat_of(d));
    end
  endtask

  initial begin
    int lat, gap, snap [4];
    logic [7:0] yy;
    logic seen;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
    end

    repeat (5) begin
      st[0] = 1'($urandom);
      av[0] = 8'($urandom);
      bv[0] = 8'($urandom);
      @(negedge clk);
      check("rst_busy", 32'(bsy[0]), 0);
      check("rst_done", 32'(dn[0]), 0);
      check("rst_y", yget(0), 0);
    end
    st[0] = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_done", 32'(dn[0]), 0);
      check("idle_busy", 32'(bsy[0]), 0);
    end

    run_op(0, 8'h57, 8'h83, lat, yy);
    check("fips_57x83", yy, 8'hC1);
    check("fips_57x83_lat", lat, 8);
    run_op(0, 8'h57, 8'h13, lat, yy);
    check("fips_57x13", yy, 8'hFE);
    run_op(0, 8'h80, 8'h02, lat, yy);
    check("fips_80x02", yy, 8'h1B);
    run_op(0, 8'h53, 8'hCA, lat, yy);
    check("fips_53xca", yy, 8'h01);

    run_op(1, 8'h57, 8'h83, lat, yy);
    check("k2_57x83", yy, 8'hC1);
    check("k2_lat", lat, 4);
    run_op(2, 8'h57, 8'h83, lat, yy);
    check("k8_57x83", yy, 8'hC1);
    check("k8_lat", lat, 1);
    run_op(3, 8'h08, 8'h02, lat, yy);
    check("w4_8x2", yy, 8'h03);
    check("w4_lat", lat, 4);
    run_op(3, 8'h0F, 8'h0F, lat, yy);
    check("w4_fxf", yy, 8'h0A);

    // start pulses at cycles 1, 4 and 7 of a run must be ignored
    @(negedge clk);
    av[0] = 8'h57; bv[0] = 8'h83; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    gap = 0;
    while (!dn[0] && gap < 40) begin
      if (gap == 1 || gap == 4 || gap == 7) begin
        st[0] = 1'b1;
        av[0] = 8'($urandom_range(1, 255));
        bv[0] = 8'($urandom_range(2, 255));
      end else begin
        st[0] = 1'b0;
      end
      @(negedge clk);
      gap++;
    end
    st[0] = 1'b0;
    check("ign_y", yget(0), 8'hC1);
    check("ign_lat", gap, 8);
    @(negedge clk);
    check("ign_no_restart", 32'(bsy[0]), 0);

    // start held high through done: second op accepted on the next edge
    av[0] = 8'h57; bv[0] = 8'h83; st[0] = 1'b1;
    @(negedge clk);
    gap = 0;
    while (!dn[0] && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_first_y", yget(0), 8'hC1);
    av[0] = 8'h02; bv[0] = 8'h03;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) begin
        st[0] = 1'b0;
        check("b2b_accept_busy", 32'(bsy[0]), 1);
      end
    end while (!dn[0] && gap < 40);
    check("b2b_second_y", yget(0), 8'h06);
    check("b2b_spacing", gap, 9);

    // reset at cycle 3 of a run aborts it
    @(negedge clk);
    av[0] = 8'h57; bv[0] = 8'h83; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bsy[0]), 0);
    check("abort_y", yget(0), 0);
    check("abort_done", 32'(dn[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dn[0]) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    run_op(0, 8'h02, 8'h03, lat, yy);
    check("post_abort_02x03", yy, 8'h06);

    @(negedge clk);
    for (int i = 0; i < 4; i++) snap[i] = dcount[i];
    for (int d = 0; d < 4; d++) begin
      automatic int dd = d;
      fork
        rand_proc(dd);
      join_none
    end
    wait fork;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("rand%0d_done_count", i), dcount[i] - snap[i], NOPS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
